instrs_buff: RTL and testbench

- Circular instruction buffer between fetch and decode.
- Accepts fetched {pc, instr} pairs from fetch and presents them in order to decode.
- Flushes on redirect ("reload").
- Exports head/tail/reload status every cycle for the DPI-C instruction-buffer performance probe.

---
 rtl/instrs_buff_pkg.sv | 18 +
 rtl/instrs_buff_ptr.sv | 33 +++
 rtl/instrs_buff.sv | 91 +++++++++
 tb/tb_instrs_buff.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/instrs_buff_pkg.sv
// Shared types and constants for the fetch-to-decode instruction buffer.
package instrs_buff_pkg;

  // Perf probe fields are uint8_t on the C side.
  localparam int unsigned PERF_PTR_W = 8;
  localparam int unsigned MAX_DEPTH  = 128;

  // Default-width entry layout (32-bit pc, 32-bit instruction).
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ib_entry_t;

  function automatic bit depth_ok(int unsigned d);
    return (d >= 2) && (d <= MAX_DEPTH) && ((d & (d - 1)) == 0);
  endfunction

endpackage

// File: rtl/instrs_buff_ptr.sv
// Wrap-bit ring pointer: IDX_W index bits plus one lap bit, with clear priority.
module instrs_buff_ptr #(
  parameter int unsigned IDX_W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           inc_i,
  input  logic           clr_i,
  output logic [IDX_W:0] ptr_o
);

  logic [IDX_W:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = ptr_q + (IDX_W + 1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/instrs_buff.sv
// Circular {pc, instr} buffer between fetch and decode with flush and perf probe outputs.
module instrs_buff
  import instrs_buff_pkg::*;
#(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned PC_WIDTH   = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [PC_WIDTH-1:0]     in_pc,
  input  logic [DATA_WIDTH-1:0]   in_instr,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [PC_WIDTH-1:0]     out_pc,
  output logic [DATA_WIDTH-1:0]   out_instr,
  input  logic                    flush,
  output logic [$clog2(DEPTH):0]  count,
  output logic [PERF_PTR_W-1:0]   perf_head,
  output logic [PERF_PTR_W-1:0]   perf_tail,
  output logic [PERF_PTR_W-1:0]   perf_reload
);

  localparam int unsigned AW = $clog2(DEPTH);

  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("instrs_buff: DEPTH must be a power of two in 2..128");
  end

  typedef struct packed {
    logic [PC_WIDTH-1:0]   pc;
    logic [DATA_WIDTH-1:0] instr;
  } entry_t;

  entry_t mem_q [DEPTH];

  logic [AW:0] head_q, tail_q;
  logic        reload_q;
  logic        empty, full, push, pop;
  entry_t      head_e;

  assign empty = (head_q == tail_q);
  assign full  = (head_q[AW-1:0] == tail_q[AW-1:0]) && (head_q[AW] != tail_q[AW]);

  // Flush wins over both transfers; out_valid may still show during it.
  assign in_ready  = !full && !flush;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready && !flush;

  instrs_buff_ptr #(.IDX_W(AW)) u_head (
    .clk   (clk),
    .rst_n (rst),
    .inc_i (pop),
    .clr_i (flush),
    .ptr_o (head_q)
  );

  instrs_buff_ptr #(.IDX_W(AW)) u_tail (
    .clk   (clk),
    .rst_n (rst),
    .inc_i (push),
    .clr_i (flush),
    .ptr_o (tail_q)
  );

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[tail_q[AW-1:0]] <= '{pc: in_pc, instr: in_instr};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reload_q <= 1'b0;
    end else begin
      reload_q <= flush;
    end
  end

  assign head_e      = mem_q[head_q[AW-1:0]];
  assign out_pc      = head_e.pc;
  assign out_instr   = head_e.instr;
  assign count       = tail_q - head_q;
  assign perf_head   = PERF_PTR_W'(head_q[AW-1:0]);
  assign perf_tail   = PERF_PTR_W'(tail_q[AW-1:0]);
  assign perf_reload = PERF_PTR_W'(reload_q);

endmodule

// File: tb/tb_instrs_buff.sv
// Scoreboard bench for instrs_buff: queue-based reference model plus directed and random stimulus.
module tb_instrs_buff;

  localparam int unsigned DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0;
  logic [31:0] in_instr = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        flush = 1'b0;
  logic [4:0]  count;
  logic [7:0]  perf_head, perf_tail, perf_reload;

  instrs_buff #(.DEPTH(DEPTH), .DATA_WIDTH(32), .PC_WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_pc       (in_pc),
    .in_instr    (in_instr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_instr   (out_instr),
    .flush       (flush),
    .count       (count),
    .perf_head   (perf_head),
    .perf_tail   (perf_tail),
    .perf_reload (perf_reload)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO contents plus lifetime push/pop counts since the last clear.
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  ent_t        sb[$];
  int unsigned pushes = 0;
  int unsigned pops = 0;
  bit          reload_exp = 1'b0;
  bit          m_push, m_pop;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb.delete();
      pushes = 0;
      pops = 0;
      reload_exp = 1'b0;
    end else begin
      reload_exp = flush;
      if (flush) begin
        sb.delete();
        pushes = 0;
        pops = 0;
      end else begin
        m_pop  = out_ready && (sb.size() > 0);
        m_push = in_valid && (sb.size() < DEPTH);
        if (m_pop) begin
          void'(sb.pop_front());
          pops++;
        end
        if (m_push) begin
          sb.push_back('{pc: in_pc, instr: in_instr});
          pushes++;
        end
      end
    end
  end

  // Monitor: compares DUT state and head entry against the model between edges.
  int unsigned n_exp;
  always @(negedge clk) begin
    n_exp = sb.size();
    chk("count", 64'(count), 64'(n_exp));
    chk("out_valid", 64'(out_valid), 64'(n_exp != 0));
    chk("in_ready", 64'(in_ready), 64'((n_exp < DEPTH) && !flush));
    chk("perf_head", 64'(perf_head), 64'(pops % DEPTH));
    chk("perf_tail", 64'(perf_tail), 64'(pushes % DEPTH));
    chk("perf_reload", 64'(perf_reload), 64'(reload_exp));
    if (out_valid && n_exp != 0) begin
      chk("out_pc", 64'(out_pc), 64'(sb[0].pc));
      chk("out_instr", 64'(out_instr), 64'(sb[0].instr));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int unsigned k = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (count != 0 && k < 64) begin
      tick();
      k++;
    end
    chk("drain_count", 64'(count), 64'd0);
    out_ready = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_reload", 64'(perf_reload), 64'd1);
  endtask

  int unsigned maxc;

  initial begin
    repeat (2) tick();
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_perf", 64'({perf_head, perf_tail, perf_reload}), 64'd0);
    rst = 1'b1;

    // Three pushes with decode stalled.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_pc    = 32'h100 + 32'(4 * i);
      in_instr = $urandom;
      tick();
      if (i == 0) begin
        chk("first_out_valid", 64'(out_valid), 64'd1);
        chk("first_out_pc", 64'(out_pc), 64'h100);
      end
    end
    in_valid = 1'b0;
    chk("t1_count", 64'(count), 64'd3);
    chk("t1_perf_tail", 64'(perf_tail), 64'd3);
    chk("t1_perf_head", 64'(perf_head), 64'd0);
    drain();

    do_flush();
    tick();
    chk("reload_clear", 64'(perf_reload), 64'd0);

    // Fill to capacity, then offer a 17th.
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_pc    = 32'h200 + 32'(4 * i);
      in_instr = $urandom;
      tick();
    end
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_count", 64'(count), 64'd16);
    chk("full_perf_tail", 64'(perf_tail), 64'd0);
    in_pc = 32'hDEAD;
    tick();
    chk("refuse_17th", 64'(count), 64'd16);

    // Full: pop and push offered together.
    out_ready = 1'b1;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("full_pop_count", 64'(count), 64'd15);
    chk("full_pop_in_ready", 64'(in_ready), 64'd1);
    drain();

    // Streaming 40 entries with decode always ready.
    do_flush();
    maxc = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      in_valid = 1'b1;
      in_pc    = 32'(4 * i);
      in_instr = $urandom;
      tick();
      if (count > maxc) maxc = count;
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    chk("stream_max_le2", 64'(maxc <= 2), 64'd1);
    chk("stream_count", 64'(count), 64'd0);
    chk("stream_perf_head", 64'(perf_head), 64'd8);
    chk("stream_perf_tail", 64'(perf_tail), 64'd8);

    // Flush at count=5 with push and pop both offered.
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_pc    = 32'h300 + 32'(4 * i);
      in_instr = $urandom;
      tick();
    end
    chk("pre_flush_count", 64'(count), 64'd5);
    flush = 1'b1;
    out_ready = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_perf_ptrs", 64'({perf_head, perf_tail}), 64'd0);
    chk("flush_reload_set", 64'(perf_reload), 64'd1);
    tick();
    chk("flush_reload_drop", 64'(perf_reload), 64'd0);

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_pc    = 32'h400 + 32'(4 * i);
      in_instr = $urandom;
      tick();
    end
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_perf", 64'({perf_head, perf_tail, perf_reload}), 64'd0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    in_valid = 1'b1;
    in_pc    = 32'h5000;
    in_instr = 32'hCAFE_F00D;
    tick();
    in_valid = 1'b0;
    chk("post_rst_valid", 64'(out_valid), 64'd1);
    chk("post_rst_pc", 64'(out_pc), 64'h5000);
    chk("post_rst_instr", 64'(out_instr), 64'hCAFE_F00D);
    drain();

    // Random traffic with occasional flushes.
    for (int i = 0; i < 500; i++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) == 0;
      flush     = ($urandom % 30) == 0;
      in_pc     = $urandom;
      in_instr  = $urandom;
      tick();
    end
    flush = 1'b0;
    drain();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
